mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences one shared ALU, one unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback steps. It decodes op/funct into per-state datapath strobes and stalls on a memory-ready handshake. It sits between the instruction register and the datapath muxes and enables, and replaces per-instruction single-cycle control.

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 31 +++
 rtl/mips_multicycle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcode and funct
// constants, FSM state encodings, and datapath mux / ALU control encodings.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // FSM states; codes 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // ALU operation encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Internal alu_op between the main FSM and the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps the FSM's alu_op and the instruction funct field to the
// 3-bit ALU control. Purely combinational.
//   alu_op      in  2  00 add, 01 sub, 10 decode funct
//   funct       in  6  IR[5:0]
//   alu_control out 3  ALU operation
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;  // includes FN_ADD
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback steps over a shared ALU and a unified memory
// port, stalling memory states on mem_ready.
//   clk, rst_n          clock and synchronous active-low reset
//   op, funct           instruction fields from the IR
//   zero                ALU zero flag (branch condition)
//   mem_ready           memory completes the current access this cycle
//   pc_en .. pc_src     datapath enables and mux selects
//   illegal_op          pulse in DECODE for an unknown opcode
//   instr_retired       count of completed instructions (wraps)
//   state_dbg           current state code
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       pc_src,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_retired,
    output logic [3:0]       state_dbg
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0] alu_op;
    logic       alu_used;
    logic [2:0] dec_control;
    logic       retire;

    // Ungated strobes; the ones that can disturb architectural state are
    // masked by rst_n below so a reset cycle never writes anything.
    logic pc_en_raw, mem_read_raw, mem_write_raw, ir_write_raw;
    logic reg_write_raw, illegal_raw;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (dec_control)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_en_raw     = 1'b0;
        iord          = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        alu_used      = 1'b0;
        pc_src        = PC_ALU;
        illegal_raw   = 1'b0;
        retire        = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                alu_used     = 1'b1;
                // PC+4 and IR load commit only on the cycle the read lands
                pc_en_raw    = mem_ready;
                ir_write_raw = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b = SRCB_IMM_SH;
                alu_used  = 1'b1;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_used  = 1'b1;
                state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                alu_used  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                alu_used  = 1'b1;
                pc_src    = PC_ALUOUT;
                pc_en_raw = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_used  = 1'b1;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_src    = PC_JUMP;
                pc_en_raw = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;  // unused codes: recover silently
        endcase

        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // ALU control reads 000 in states that do not drive the ALU
    assign alu_control   = alu_used ? dec_control : 3'b000;

    assign pc_en         = pc_en_raw     & rst_n;
    assign mem_read      = mem_read_raw  & rst_n;
    assign mem_write     = mem_write_raw & rst_n;
    assign ir_write      = ir_write_raw  & rst_n;
    assign reg_write     = reg_write_raw & rst_n;
    assign illegal_op    = illegal_raw   & rst_n;

    assign instr_retired = cnt_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl. Stimulus walks directed instruction
// sequences cycle by cycle and queues the hand-derived expected state, strobe
// vector and retired count for each cycle; a monitor on the falling edge
// pops each entry and compares it against the DUT.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic        mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_control;
    logic [31:0] instr_retired;
    logic [3:0]  state_dbg;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .pc_src        (pc_src),
        .illegal_op    (illegal_op),
        .instr_retired (instr_retired),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    // Strobe vector layout:
    // {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
    //  reg_write, alu_src_a, alu_src_b[1:0], alu_control[2:0], pc_src[1:0],
    //  illegal_op}
    localparam logic [16:0] X_FETCH_R  = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,2'b00,1'b0};
    localparam logic [16:0] X_FETCH_W  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,2'b00,1'b0};
    localparam logic [16:0] X_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b010,2'b00,1'b0};
    localparam logic [16:0] X_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b010,2'b00,1'b1};
    localparam logic [16:0] X_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,2'b00,1'b0};
    localparam logic [16:0] X_MEMREAD  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
    localparam logic [16:0] X_MRD_RST  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
    localparam logic [16:0] X_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
    localparam logic [16:0] X_MEMWRITE = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
    localparam logic [16:0] X_EXEC_ADD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010,2'b00,1'b0};
    localparam logic [16:0] X_EXEC_SUB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b00,1'b0};
    localparam logic [16:0] X_EXEC_SLT = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b111,2'b00,1'b0};
    localparam logic [16:0] X_ALUWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
    localparam logic [16:0] X_BR_TAKEN = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b01,1'b0};
    localparam logic [16:0] X_BR_NOT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b01,1'b0};
    localparam logic [16:0] X_ADDIEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,2'b00,1'b0};
    localparam logic [16:0] X_ADDIWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
    localparam logic [16:0] X_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10,1'b0};

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [16:0] v;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic stim_done = 1'b0;

    // Queue this cycle's expectation, then advance one clock
    task automatic cyc(input string name, input logic [3:0] st,
                       input logic [16:0] v, input logic [31:0] cnt);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.v    = v;
        e.cnt  = cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the controller presents a full output set every cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [16:0] act;
            e   = exp_q.pop_front();
            act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control,
                   pc_src, illegal_op};
            n_checks++;
            if (state_dbg === e.st && act === e.v && instr_retired === e.cnt)
                n_pass++;
            else
                $display("FAIL %s: got state=%0d strobes=%b cnt=%0d, want state=%0d strobes=%b cnt=%0d",
                         e.name, state_dbg, act, instr_retired, e.st, e.v, e.cnt);
        end
    end

    initial begin
        rst_n = 1'b0; op = 6'b000000; funct = 6'b100000;
        zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // R-type add: 0,1,6,7
        cyc("rst_fetch",   4'd0, X_FETCH_R,  0);
        cyc("radd_decode", 4'd1, X_DECODE,   0);
        cyc("radd_exec",   4'd6, X_EXEC_ADD, 0);
        cyc("radd_wb",     4'd7, X_ALUWB,    0);

        // R-type sub and slt exercise the funct decode
        funct = 6'b100010;
        cyc("rsub_fetch",  4'd0, X_FETCH_R,  1);
        cyc("rsub_decode", 4'd1, X_DECODE,   1);
        cyc("rsub_exec",   4'd6, X_EXEC_SUB, 1);
        cyc("rsub_wb",     4'd7, X_ALUWB,    1);
        funct = 6'b101010;
        cyc("rslt_fetch",  4'd0, X_FETCH_R,  2);
        cyc("rslt_decode", 4'd1, X_DECODE,   2);
        cyc("rslt_exec",   4'd6, X_EXEC_SLT, 2);
        cyc("rslt_wb",     4'd7, X_ALUWB,    2);

        // LW with two wait cycles in MEMREAD: 7 cycles
        op = 6'b100011;
        cyc("lw_fetch",    4'd0, X_FETCH_R,  3);
        cyc("lw_decode",   4'd1, X_DECODE,   3);
        cyc("lw_memadr",   4'd2, X_MEMADR,   3);
        mem_ready = 1'b0;
        cyc("lw_mrd_w0",   4'd3, X_MEMREAD,  3);
        cyc("lw_mrd_w1",   4'd3, X_MEMREAD,  3);
        mem_ready = 1'b1;
        cyc("lw_mrd_rdy",  4'd3, X_MEMREAD,  3);
        cyc("lw_memwb",    4'd4, X_MEMWB,    3);

        // BEQ taken then not taken
        op = 6'b000100; zero = 1'b1;
        cyc("beqt_fetch",  4'd0, X_FETCH_R,  4);
        cyc("beqt_decode", 4'd1, X_DECODE,   4);
        cyc("beqt_branch", 4'd8, X_BR_TAKEN, 4);
        zero = 1'b0;
        cyc("beqn_fetch",  4'd0, X_FETCH_R,  5);
        cyc("beqn_decode", 4'd1, X_DECODE,   5);
        cyc("beqn_branch", 4'd8, X_BR_NOT,   5);

        // SW with one stalled FETCH cycle, then J
        op = 6'b101011; mem_ready = 1'b0;
        cyc("sw_fetch_w",  4'd0, X_FETCH_W,  6);
        mem_ready = 1'b1;
        cyc("sw_fetch",    4'd0, X_FETCH_R,  6);
        cyc("sw_decode",   4'd1, X_DECODE,   6);
        cyc("sw_memadr",   4'd2, X_MEMADR,   6);
        cyc("sw_memwrite", 4'd5, X_MEMWRITE, 6);
        op = 6'b000010;
        cyc("j_fetch",     4'd0, X_FETCH_R,  7);
        cyc("j_decode",    4'd1, X_DECODE,   7);
        cyc("j_jump",      4'd11, X_JUMP,    7);

        // ADDI
        op = 6'b001000;
        cyc("addi_fetch",  4'd0, X_FETCH_R,  8);
        cyc("addi_decode", 4'd1, X_DECODE,   8);
        cyc("addi_ex",     4'd9, X_ADDIEX,   8);
        cyc("addi_wb",     4'd10, X_ADDIWB,  8);

        // Illegal opcode: pulse in DECODE, no retire
        op = 6'b111111;
        cyc("ill_fetch",   4'd0, X_FETCH_R,  9);
        cyc("ill_decode",  4'd1, X_DEC_ILL,  9);
        op = 6'b100011;
        cyc("ill_after",   4'd0, X_FETCH_R,  9);

        // LW aborted by reset while stalled in MEMREAD
        cyc("lwr_decode",  4'd1, X_DECODE,   9);
        cyc("lwr_memadr",  4'd2, X_MEMADR,   9);
        mem_ready = 1'b0;
        cyc("lwr_mrd",     4'd3, X_MEMREAD,  9);
        rst_n = 1'b0;
        cyc("lwr_rst",     4'd3, X_MRD_RST,  9);
        rst_n = 1'b1; mem_ready = 1'b1;
        cyc("lwr_restart", 4'd0, X_FETCH_R,  0);

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        if (budget >= 2000) begin
            n_checks++;
            $display("FAIL timeout: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
